pwmservo_axil_slave: RTL and testbench

//  AXI4-Lite responder inside the pwmservo IP: four 32-bit read/write registers plus the servo PWM generator they control.

---
 rtl/pwmservo_pkg.sv | 30 +++
 rtl/pwmservo_pwm_core.sv | 58 +++++
 rtl/pwmservo_axil_slave.sv | 111 +++++++++++
 tb/tb_pwmservo_axil_slave.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwmservo_pkg.sv
// Shared register map, response codes and PWM configuration type for the pwmservo IP.
package pwmservo_pkg;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 4;

  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_PERIOD   = 2'd1;
  localparam logic [1:0] REG_PULSE    = 2'd2;
  localparam logic [1:0] REG_PRESCALE = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam int         CTRL_EN_BIT = 0;

  typedef struct packed {
    logic              en;
    logic [DATA_W-1:0] period;
    logic [DATA_W-1:0] pulse;
    logic [DATA_W-1:0] prescale;
  } pwm_cfg_t;

  function automatic logic [DATA_W-1:0] strb_merge(input logic [DATA_W-1:0] old_val,
                                                   input logic [DATA_W-1:0] new_val,
                                                   input logic [DATA_W/8-1:0] strb);
    logic [DATA_W-1:0] r;
    r = old_val;
    for (int b = 0; b < DATA_W/8; b++)
      if (strb[b]) r[b*8 +: 8] = new_val[b*8 +: 8];
    return r;
  endfunction
endpackage

// File: rtl/pwmservo_pwm_core.sv
// Servo PWM engine: prescaler, period counter, registered compare.
// PWMSERVO_SHADOW_EN: period/pulse/prescale are shadowed and only reloaded at counter wrap or while idle.
module pwmservo_pwm_core
  import pwmservo_pkg::*;
(
  input  logic     gclk,
  input  logic     grst_n,
  input  pwm_cfg_t cfg,
  output logic     pwm_out,
  output logic     period_tick
);
  logic [DATA_W-1:0] psc, cnt;
  logic [DATA_W-1:0] act_period, act_pulse, act_prescale;
  logic              step, wrap;

  assign step = cfg.en && (psc >= act_prescale);
  assign wrap = step && (act_period != '0) && (cnt >= act_period - DATA_W'(1));

`ifdef PWMSERVO_SHADOW_EN
  // A zero period never wraps, so treat it as idle and keep loading; otherwise it could never be left.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      act_period   <= '0;
      act_pulse    <= '0;
      act_prescale <= '0;
    end else if (!cfg.en || wrap || act_period == '0) begin
      act_period   <= cfg.period;
      act_pulse    <= cfg.pulse;
      act_prescale <= cfg.prescale;
    end
  end
`else
  always_comb begin
    act_period   = cfg.period;
    act_pulse    = cfg.pulse;
    act_prescale = cfg.prescale;
  end
`endif

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      psc         <= '0;
      cnt         <= '0;
      pwm_out     <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      period_tick <= wrap;
      pwm_out     <= cfg.en && (act_period != '0) && (cnt < act_pulse);
      if (!cfg.en) begin
        psc <= '0;
        cnt <= '0;
      end else begin
        psc <= step ? '0 : psc + DATA_W'(1);
        if (step) cnt <= (act_period == '0 || wrap) ? '0 : cnt + DATA_W'(1);
      end
    end
  end
endmodule

// File: rtl/pwmservo_axil_slave.sv
// AXI4-Lite register slave (CTRL/PERIOD/PULSE/PRESCALE) driving the servo PWM core.
// Define PWMSERVO_SHADOW_EN for glitch-free, wrap-aligned PWM parameter updates.
module pwmservo_axil_slave
  import pwmservo_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            pwm_out,
  output logic                            period_tick
);
  localparam int IDX_LSB = 2;

  logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0] regs;
  logic                                        aw_held, w_held;
  logic [1:0]                                  aw_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0]               wdata_q;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]             wstrb_q;
  pwm_cfg_t                                    cfg;
  logic                                        unused_ok;

  assign unused_ok   = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  assign S_AXI_BRESP = RESP_OKAY;
  assign S_AXI_RRESP = RESP_OKAY;

  // Write path: each channel parks one beat; commit once both are parked, then hold off until B completes.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_idx        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      regs          <= '0;
    end else begin
      S_AXI_AWREADY <= S_AXI_AWVALID && !S_AXI_AWREADY && !aw_held && !S_AXI_BVALID;
      S_AXI_WREADY  <= S_AXI_WVALID && !S_AXI_WREADY && !w_held && !S_AXI_BVALID;
      if (S_AXI_AWVALID && S_AXI_AWREADY) begin
        aw_held <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[IDX_LSB +: 2];
      end
      if (S_AXI_WVALID && S_AXI_WREADY) begin
        w_held  <= 1'b1;
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      if (aw_held && w_held) begin
        regs[aw_idx] <= strb_merge(regs[aw_idx], wdata_q, wstrb_q);
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
        S_AXI_BVALID <= 1'b1;
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
    end
  end

  // Read path: data is captured from the pre-commit register value in the ARREADY cycle.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
    end else begin
      S_AXI_ARREADY <= S_AXI_ARVALID && !S_AXI_ARREADY && !S_AXI_RVALID;
      if (S_AXI_ARVALID && S_AXI_ARREADY) begin
        S_AXI_RDATA  <= regs[S_AXI_ARADDR[IDX_LSB +: 2]];
        S_AXI_RVALID <= 1'b1;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

  assign cfg = '{en:       regs[REG_CTRL][CTRL_EN_BIT],
                 period:   regs[REG_PERIOD],
                 pulse:    regs[REG_PULSE],
                 prescale: regs[REG_PRESCALE]};

  pwmservo_pwm_core u_pwm (
    .gclk        (S_AXI_ACLK),
    .grst_n      (S_AXI_ARESETN),
    .cfg         (cfg),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );
endmodule

// File: tb/tb_pwmservo_axil_slave.sv
// Scoreboard bench for pwmservo_axil_slave: directed bus and PWM vectors, monitor-side checking.
module tb_pwmservo_axil_slave;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid, pwm_out, period_tick;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int vectors = 0, miscompares = 0;

  typedef struct { string name; logic [31:0] data; } rexp_t;
  typedef struct { string name; logic pwm; logic tick; logic chk_tick; } pexp_t;
  string b_q[$];
  rexp_t r_q[$];
  pexp_t p_q[$];

  always #5 clk = ~clk;

  pwmservo_axil_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .pwm_out(pwm_out), .period_tick(period_tick)
  );

  // Monitor: pops an expectation whenever the DUT completes a response or a PWM sample is due.
  always @(negedge clk) begin
    string n;
    rexp_t re;
    pexp_t pe;
    if (rst_n) begin
      if (bvalid && bready) begin
        vectors++;
        if (b_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_b: got BVALID, expected no pending write");
        end else begin
          n = b_q.pop_front();
          if (bresp !== 2'b00) begin
            miscompares++;
            $display("FAIL %s: got BRESP %b expected 00", n, bresp);
          end
        end
      end
      if (rvalid && rready) begin
        vectors++;
        if (r_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_r: got RVALID data %h, expected no pending read", rdata);
        end else begin
          re = r_q.pop_front();
          if ({rresp, rdata} !== {2'b00, re.data}) begin
            miscompares++;
            $display("FAIL %s: got RRESP %b RDATA %h expected 00 %h", re.name, rresp, rdata, re.data);
          end
        end
      end
      if (p_q.size() > 0) begin
        pe = p_q.pop_front();
        vectors++;
        if (pwm_out !== pe.pwm || (pe.chk_tick && period_tick !== pe.tick)) begin
          miscompares++;
          $display("FAIL %s: got pwm %b tick %b expected pwm %b tick %b", pe.name, pwm_out,
                   period_tick, pe.pwm, pe.chk_tick ? pe.tick : period_tick);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  task automatic wait_b(input string name);
    bit hit = 1'b0;
    bready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bvalid) begin hit = 1'b1; break; end
    end
    @(posedge clk); #1;
    bready = 1'b0;
    if (!hit) begin
      timeout(name);
      void'(b_q.pop_back());
    end
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input string name);
    bit a_ok = 1'b0, w_ok = 1'b0, a_s, w_s;
    b_q.push_back(name);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 50 && !(a_ok && w_ok); i++) begin
      @(negedge clk);
      a_s = awvalid && awready;
      w_s = wvalid && wready;
      @(posedge clk); #1;
      if (a_s) begin a_ok = 1'b1; awvalid = 1'b0; end
      if (w_s) begin w_ok = 1'b1; wvalid = 1'b0; end
    end
    if (!(a_ok && w_ok)) begin
      timeout({name, "_addr_data"});
      awvalid = 1'b0; wvalid = 1'b0;
    end
    wait_b(name);
  endtask

  task automatic issue_ar(input logic [3:0] addr, input string name);
    bit hit = 1'b0, s;
    araddr = addr; arvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      s = arready;
      @(posedge clk); #1;
      if (s) begin hit = 1'b1; break; end
    end
    arvalid = 1'b0;
    if (!hit) timeout({name, "_ar"});
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp, input string name);
    bit hit = 1'b0;
    r_q.push_back('{name, exp});
    issue_ar(addr, name);
    rready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rvalid) begin hit = 1'b1; break; end
    end
    @(posedge clk); #1;
    rready = 1'b0;
    if (!hit) begin
      timeout(name);
      void'(r_q.pop_back());
    end
  endtask

  // Period-10 pattern relative to an observed tick at k=0; pulse p0 in first period, p1 after.
  task automatic push_pwm(input string name, input int n, input int p0, input int p1);
    pexp_t e;
    for (int k = 1; k <= n; k++) begin
      e.name     = name;
      e.pwm      = ((k % 10) >= 1) && ((k % 10) <= ((k <= 10) ? p0 : p1));
      e.tick     = (k % 10) == 0;
      e.chk_tick = 1'b1;
      p_q.push_back(e);
    end
  endtask

  task automatic push_const(input string name, input int n, input logic pwm, input logic chk_tick);
    for (int k = 0; k < n; k++) p_q.push_back('{name, pwm, 1'b0, chk_tick});
  endtask

  task automatic wait_tick(input string name);
    bit hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (period_tick) begin hit = 1'b1; break; end
    end
    if (!hit) timeout(name);
    #1;
  endtask

  // Let a config change reach the core in either build (shadow reload happens at a wrap).
  task automatic settle();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (period_tick) break;
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (b_q.size() == 0 && r_q.size() == 0 && p_q.size() == 0) break;
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1);
  end

  initial begin
    bit hit;
    bit ws;
    repeat (3) @(negedge clk);
    check("reset_outputs", {awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata, pwm_out, period_tick}, '0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // 1: all four registers, full writes
    axi_write(4'h0, 32'h1, 4'hF, "t1_w_ctrl");
    axi_write(4'h4, 32'h2, 4'hF, "t1_w_period");
    axi_write(4'h8, 32'h3, 4'hF, "t1_w_pulse");
    axi_write(4'hC, 32'h4, 4'hF, "t1_w_prescale");
    axi_read(4'h0, 32'h1, "t1_r_ctrl");
    axi_read(4'h4, 32'h2, "t1_r_period");
    axi_read(4'h8, 32'h3, "t1_r_pulse");
    axi_read(4'hC, 32'h4, "t1_r_prescale");

    // 2: byte-lane merge
    axi_write(4'h8, 32'h0, 4'hF, "t2_clear");
    axi_write(4'h8, 32'hAABBCCDD, 4'b0010, "t2_strb");
    axi_read(4'h8, 32'h0000CC00, "t2_r_merge");

    // 3: W three cycles ahead of AW, B back-pressured for five cycles
    b_q.push_back("t3_b");
    wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1; awaddr = 4'hC;
    repeat (3) begin
      @(negedge clk); ws = wready;
      @(posedge clk); #1;
      if (ws) wvalid = 1'b0;
    end
    awvalid = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); ws = awready;
      @(posedge clk); #1;
      if (ws) begin hit = 1'b1; break; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!hit) timeout("t3_aw");
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bvalid) begin hit = 1'b1; break; end
    end
    if (!hit) timeout("t3_bvalid");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_bvalid_held", {63'd0, bvalid}, 64'd1);
    end
    @(posedge clk); #1;
    bready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bready = 1'b0;
    axi_read(4'hC, 32'h55, "t3_r_prescale");

    // 4: 3/10 duty, prescale 0
    axi_write(4'h0, 32'h0, 4'hF, "t4_dis");
    axi_write(4'hC, 32'h0, 4'hF, "t4_prescale");
    axi_write(4'h4, 32'd10, 4'hF, "t4_period");
    axi_write(4'h8, 32'd3, 4'hF, "t4_pulse");
    axi_write(4'h0, 32'h1, 4'hF, "t4_en");
    wait_tick("t4_first_tick");
    push_pwm("t4_pwm", 20, 3, 3);
    drain();

    // 5: pulse beyond period, then zero period
    axi_write(4'h8, 32'd12, 4'hF, "t5_pulse12");
    settle();
    push_const("t5_full_on", 12, 1'b1, 1'b0);
    drain();
    axi_write(4'h4, 32'd0, 4'hF, "t5_period0");
    settle();
    push_const("t5_period0", 15, 1'b0, 1'b1);
    drain();

    // 6: reset while a read response is pending
    axi_write(4'h4, 32'd10, 4'hF, "t6_period");
    settle();
    check("t6_pwm_before_reset", {63'd0, pwm_out}, 64'd1);
    issue_ar(4'h8, "t6_read");
    rready = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rvalid) begin hit = 1'b1; break; end
    end
    if (!hit) timeout("t6_rvalid");
    #1 rst_n = 1'b0;
    #1 check("t6_reset_abort", {rvalid, arready, bvalid, rdata, pwm_out, period_tick}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    axi_read(4'h0, 32'h0, "t6_r_ctrl");
    axi_read(4'h4, 32'h0, "t6_r_period");
    axi_read(4'h8, 32'h0, "t6_r_pulse");
    axi_read(4'hC, 32'h0, "t6_r_prescale");

`ifdef PWMSERVO_SHADOW_EN
    // Pulse change mid-period only lands after the next wrap
    axi_write(4'h4, 32'd10, 4'hF, "sh_period");
    axi_write(4'h8, 32'd3, 4'hF, "sh_pulse3");
    axi_write(4'h0, 32'h1, 4'hF, "sh_en");
    wait_tick("sh_tick");
    push_pwm("sh_pwm", 20, 3, 6);
    axi_write(4'h8, 32'd6, 4'hF, "sh_pulse6");
    drain();
    axi_read(4'h8, 32'd6, "sh_r_pulse");
`endif

    drain();
    check("queues_drained", 64'(b_q.size() + r_q.size() + p_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
